// File: rtl/c1541_sd_arb.sv
// Round-robin arbiter sharing one SD block port among up to four C1541 drive ports.
// Optional REQ watchdog enabled by defining C1541_SD_ARB_TIMEOUT_EN.
module c1541_sd_arb #(
  parameter int DRIVES = 4,
  parameter int TMO_W  = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [32*DRIVES-1:0]  drv_lba,
  input  logic [6*DRIVES-1:0]   drv_sz,
  input  logic [DRIVES-1:0]     drv_rd,
  input  logic [DRIVES-1:0]     drv_wr,
  output logic [DRIVES-1:0]     drv_ack,
  output logic [DRIVES-1:0]     drv_buff_wr,
  input  logic [8*DRIVES-1:0]   drv_buff_din,
  output logic [DRIVES-1:0]     drv_err,
  output logic [31:0]           sd_lba,
  output logic [5:0]            sd_sz,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  rr_ptr_reg, rr_ptr_next;
  logic        op_wr_reg, op_wr_next;
  logic [31:0] lba_reg, lba_next;
  logic [5:0]  sz_reg, sz_next;
  logic [DRIVES-1:0] req;
  logic        found;
  logic [1:0]  sel;
  logic        timeout;

  assign req = drv_rd | drv_wr;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_reg;
    for (int k = DRIVES - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr_reg) + k) % DRIVES]) begin
        found = 1'b1;
        sel   = 2'((int'(rr_ptr_reg) + k) % DRIVES);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    rr_ptr_next = rr_ptr_reg;
    op_wr_next  = op_wr_reg;
    lba_next    = lba_reg;
    sz_next     = sz_reg;
    case (state_reg)
      IDLE: if (found) begin
        gnt_next   = sel;
        op_wr_next = ~drv_rd[sel];
        lba_next   = drv_lba[32*sel +: 32];
        sz_next    = drv_sz[6*sel +: 6];
        state_next = REQ;
      end
      REQ: begin
        if (sd_ack)
          state_next = XFER;
        else if (timeout)
          state_next = REL;
      end
      XFER: if (!sd_ack) state_next = REL;
      REL: begin
        rr_ptr_next = (int'(gnt_reg) == DRIVES - 1) ? 2'd0 : gnt_reg + 2'd1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg  <= IDLE;
      gnt_reg    <= 2'd0;
      rr_ptr_reg <= 2'd0;
      op_wr_reg  <= 1'b0;
      lba_reg    <= 32'd0;
      sz_reg     <= 6'd0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      rr_ptr_reg <= rr_ptr_next;
      op_wr_reg  <= op_wr_next;
      lba_reg    <= lba_next;
      sz_reg     <= sz_next;
    end
  end

`ifdef C1541_SD_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] wd_reg;

  always_ff @(posedge clk_sys) begin
    if (reset)
      wd_reg <= '0;
    else if (state_reg != REQ)
      wd_reg <= '0;
    else
      wd_reg <= wd_reg + 1'b1;
  end

  // A real ack in the same cycle takes precedence over the abort.
  assign timeout = (state_reg == REQ) && !sd_ack && (&wd_reg);
`else
  assign timeout = 1'b0;
`endif

  assign busy        = (state_reg != IDLE);
  assign sd_rd       = (state_reg == REQ) && !op_wr_reg;
  assign sd_wr       = (state_reg == REQ) && op_wr_reg;
  assign sd_lba      = lba_reg;
  assign sd_sz       = sz_reg;
  assign sd_buff_din = drv_buff_din[8*gnt_reg +: 8];

  // Ack and buffer strobes reach only the granted drive; stale acks in IDLE are dropped.
  generate
    for (genvar gi = 0; gi < DRIVES; gi++) begin : g_route
      logic sel_gi;
      assign sel_gi          = busy && (gnt_reg == 2'(gi));
      assign drv_ack[gi]     = sel_gi && sd_ack;
      assign drv_buff_wr[gi] = sel_gi && sd_ack && sd_buff_wr;
      assign drv_err[gi]     = timeout && (gnt_reg == 2'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_c1541_sd_arb.sv
// Directed-vector self-checking bench for c1541_sd_arb (DRIVES=4, TMO_W=4).
// Timeout scenario only exercised when C1541_SD_ARB_TIMEOUT_EN is defined.
module tb_c1541_sd_arb;
  localparam int DRIVES = 4;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic [32*DRIVES-1:0] drv_lba;
  logic [6*DRIVES-1:0]  drv_sz;
  logic [DRIVES-1:0]    drv_rd, drv_wr;
  logic [DRIVES-1:0]    drv_ack, drv_buff_wr, drv_err;
  logic [8*DRIVES-1:0]  drv_buff_din;
  logic [31:0]          sd_lba;
  logic [5:0]           sd_sz;
  logic                 sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]           sd_buff_din;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  c1541_sd_arb #(.DRIVES(DRIVES), .TMO_W(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .drv_lba(drv_lba), .drv_sz(drv_sz), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr), .drv_buff_din(drv_buff_din),
    .drv_err(drv_err), .sd_lba(sd_lba), .sd_sz(sd_sz), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv_rd = '0;
    drv_wr = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 8; i++) begin
      if (sd_rd || sd_wr) break;
      tick();
    end
    if (i == 8) chk({tag, "_wait"}, 32'(sd_rd | sd_wr), 32'd1);
  endtask

  // Serve one transaction: check grant identity via the latched LBA, then ack it.
  task automatic do_xfer(input int exp_drv, input bit exp_wr, input bit drop_req);
    wait_req("xfer");
    chk("grant_lba", sd_lba, 32'h100 + 32'(exp_drv));
    chk("grant_sz", 32'(sd_sz), 32'(exp_drv + 1));
    chk("op_wr", 32'(sd_wr), 32'(exp_wr));
    chk("op_rd", 32'(sd_rd), 32'(!exp_wr));
    sd_ack = 1'b1;
    #1;
    chk("ack_route", 32'(drv_ack), 32'(1 << exp_drv));
    if (drop_req) begin
      if (exp_wr) drv_wr[exp_drv] = 1'b0;
      else        drv_rd[exp_drv] = 1'b0;
    end
    tick();
    chk("ack_xfer", 32'(drv_ack), 32'(1 << exp_drv));
    chk("xfer_strobe", 32'(sd_rd | sd_wr), 32'd0);
    tick();
    sd_ack = 1'b0;
    tick();
    chk("rel_busy", 32'(busy), 32'd1);
    tick();
    $display("xfer: drive %0d %s served", exp_drv, exp_wr ? "write" : "read");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DRIVES; i++) begin
      drv_lba[32*i +: 32]    = 32'h100 + 32'(i);
      drv_sz[6*i +: 6]       = 6'(i + 1);
      drv_buff_din[8*i +: 8] = 8'(8'h11 * (i + 1));
    end
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdwr", 32'({sd_rd, sd_wr}), 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_sz", 32'(sd_sz), 32'd0);
    chk("rst_err", 32'(drv_err), 32'd0);
    $display("reset: done");

    // Single read with LBA change during the transfer
    drv_lba[31:0] = 32'h123;
    drv_rd = 4'b0001;
    #1;
    chk("rd_lat0", 32'(sd_rd), 32'd0);
    tick();
    chk("rd_lat1", 32'(sd_rd), 32'd1);
    chk("rd_lba", sd_lba, 32'h123);
    chk("rd_sz", 32'(sd_sz), 32'd1);
    chk("rd_ack_pre", 32'(drv_ack), 32'd0);
    drv_lba[31:0] = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      sd_ack = 1'b1;
      #1;
      chk("rd_ack", 32'(drv_ack), 32'd1);
      chk("rd_lba_hold", sd_lba, 32'h123);
      if (i == 0) drv_rd = 4'b0000;
      tick();
      chk("rd_strobe_off", 32'(sd_rd), 32'd0);
    end
    sd_ack = 1'b0;
    #1;
    chk("rd_ack_off", 32'(drv_ack), 32'd0);
    tick();
    chk("rd_busy_rel", 32'(busy), 32'd1);
    chk("rd_lba_rel", sd_lba, 32'h123);
    tick();
    chk("rd_busy_idle", 32'(busy), 32'd0);
    drv_lba[31:0] = 32'h100;
    $display("xfer: single read done");

    // Stale ack in IDLE
    sd_ack = 1'b1;
    #1;
    chk("stale_ack", 32'(drv_ack), 32'd0);
    tick();
    chk("stale_busy", 32'(busy), 32'd0);
    sd_ack = 1'b0;

    // Contention from reset
    do_reset();
    drv_rd = 4'b0110;
    do_xfer(1, 1'b0, 1'b1);
    do_xfer(2, 1'b0, 1'b1);

    // Fairness with both requests held
    do_reset();
    drv_rd = 4'b1001;
    do_xfer(0, 1'b0, 1'b0);
    do_xfer(3, 1'b0, 1'b0);
    do_xfer(0, 1'b0, 1'b0);
    do_xfer(3, 1'b0, 1'b0);

    // Read wins over write on the same drive; write stays pending
    do_reset();
    drv_rd = 4'b0010;
    drv_wr = 4'b0010;
    do_xfer(1, 1'b0, 1'b1);
    do_xfer(1, 1'b1, 1'b1);

    // Write data routing
    do_reset();
    drv_buff_din[23:16] = 8'hA5;
    drv_wr = 4'b0100;
    wait_req("wdat");
    chk("wdat_sdwr", 32'(sd_wr), 32'd1);
    sd_ack = 1'b1;
    sd_buff_wr = 1'b1;
    drv_wr = 4'b0000;
    #1;
    chk("wdat_din", 32'(sd_buff_din), 32'hA5);
    chk("wdat_bwr", 32'(drv_buff_wr), 32'b0100);
    sd_buff_wr = 1'b0;
    #1;
    chk("wdat_bwr_off", 32'(drv_buff_wr), 32'd0);
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    chk("wdat_idle", 32'(busy), 32'd0);
    $display("xfer: write data routing done");

    // Request dropped while waiting for ack is still completed
    drv_rd = 4'b1000;
    wait_req("drop");
    drv_rd = 4'b0000;
    tick();
    tick();
    chk("drop_hold_rd", 32'(sd_rd), 32'd1);
    chk("drop_hold_busy", 32'(busy), 32'd1);
    sd_ack = 1'b1;
    #1;
    chk("drop_ack", 32'(drv_ack), 32'b1000);
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    chk("drop_idle", 32'(busy), 32'd0);
    $display("xfer: dropped request completed");

`ifdef C1541_SD_ARB_TIMEOUT_EN
    // Watchdog: first REQ cycle is cycle 1, abort appears in cycle 16
    do_reset();
    drv_wr = 4'b0001;
    wait_req("tmo");
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (c == 15) chk("tmo_err_c15", 32'(drv_err), 32'd0);
    end
    chk("tmo_err_c16", 32'(drv_err), 32'b0001);
    chk("tmo_wr_c16", 32'(sd_wr), 32'd1);
    drv_wr = 4'b0000;
    tick();
    chk("tmo_wr_off", 32'(sd_wr), 32'd0);
    chk("tmo_err_off", 32'(drv_err), 32'd0);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
    $display("xfer: watchdog abort done");
`else
    // No watchdog: REQ waits indefinitely
    do_reset();
    drv_wr = 4'b0001;
    wait_req("stall");
    for (int c = 0; c < 40; c++) tick();
    chk("stall_wr", 32'(sd_wr), 32'd1);
    chk("stall_err", 32'(drv_err), 32'd0);
    sd_ack = 1'b1;
    drv_wr = 4'b0000;
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    chk("stall_idle", 32'(busy), 32'd0);
    $display("xfer: long stall completed");
`endif

    // Reset while in REQ and while in XFER
    drv_rd = 4'b0001;
    wait_req("rstq");
    reset = 1'b1;
    tick();
    chk("rstq_rd", 32'(sd_rd), 32'd0);
    chk("rstq_busy", 32'(busy), 32'd0);
    chk("rstq_err", 32'(drv_err), 32'd0);
    chk("rstq_lba", sd_lba, 32'd0);
    reset = 1'b0;
    wait_req("rstx");
    sd_ack = 1'b1;
    tick();
    chk("rstx_in_xfer", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("rstx_rd", 32'(sd_rd), 32'd0);
    chk("rstx_busy", 32'(busy), 32'd0);
    chk("rstx_err", 32'(drv_err), 32'd0);
    reset = 1'b0;
    sd_ack = 1'b0;
    drv_rd = 4'b0000;
    $display("reset: mid-transfer done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
